cmd_frame_parser: RTL
=====================

CMD_FRAME_PARSER -- requirements
Module: cmd_frame_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CLOCKS, default 50000, the maximum number of clocks allowed between byte 1 and byte 2 of a frame.
REQ-002 SHALL have parameter MAX_CODE, default 8'h07, the highest legal command code.
REQ-003 SHALL have parameter MAX_ADDR, default 8'h1F, the highest legal sensor address.
REQ-004 clock  input  1  single system clock; all logic on posedge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 has_data  input  1  one-cycle strobe from the UART receiver: data_received is valid this cycle.
REQ-007 data_received  input  8  received byte.
REQ-008 cmd_ready  input  1  downstream accepts the command when high with cmd_valid.
REQ-009 cmd_valid  output  1  assembled command available; held until accepted.
REQ-010 cmd_code  output  8  command code of the held frame.
REQ-011 sensor_addr  output  5  sensor address of the held frame.
REQ-012 frame_error  output  1  one-cycle pulse on an invalid code, invalid address or timeout.
REQ-013 overrun  output  1  one-cycle pulse when a byte is dropped while a command is held.

Function
REQ-014 SHALL implement states IDLE, WAIT_ADDR and HOLD.
REQ-015 IDLE + has_data with data_received <= MAX_CODE: SHALL latch the code, clear the timer and go to WAIT_ADDR.
REQ-016 IDLE + has_data with data_received > MAX_CODE: SHALL pulse frame_error next cycle and stay in IDLE.
REQ-017 WAIT_ADDR + has_data with data_received <= MAX_ADDR: SHALL load cmd_code/sensor_addr (addr = byte[4:0]), assert cmd_valid from the next cycle and go to HOLD.
REQ-018 WAIT_ADDR + has_data with data_received > MAX_ADDR: SHALL pulse frame_error and return to IDLE; no command is issued.
REQ-019 WAIT_ADDR SHALL count clocks and, with no byte after TIMEOUT_CLOCKS-1 counts, SHALL pulse frame_error and return to IDLE.
REQ-020 If has_data and the timeout coincide in the same cycle, the byte SHALL win (REQ-017/018 apply); no timeout error.
REQ-021 Latency: has_data of the address byte -> cmd_valid high on the following clock edge (1 cycle).
REQ-022 HOLD: cmd_valid, cmd_code and sensor_addr SHALL be stable until the cycle cmd_valid && cmd_ready, then go to IDLE with cmd_valid low the next cycle.
REQ-023 HOLD + has_data (no acceptance that cycle) SHALL drop the byte and pulse overrun; the held command is unchanged.
REQ-024 HOLD + has_data in the same cycle as acceptance SHALL treat the byte as byte 1 of a new frame (IDLE rules), with no overrun.
REQ-025 frame_error and overrun SHALL each be high for exactly one cycle per event and SHALL be registered outputs.
REQ-026 The timeout counter SHALL be $clog2(TIMEOUT_CLOCKS) bits wide, saturate-free and cleared on every entry to WAIT_ADDR.
REQ-027 An unknown state encoding SHALL recover to IDLE on the next clock.

Reset
REQ-028 Asserting reset SHALL immediately force state IDLE, cmd_valid=0, cmd_code=0, sensor_addr=0, frame_error=0, overrun=0 and timer=0.
REQ-029 Reset asserted mid-frame (WAIT_ADDR or HOLD) SHALL discard the partial/held frame; the first has_data after deassertion is byte 1.

Structure
REQ-030 The state encoding, MAX_CODE default and command code constants SHALL live in a shared package, cmd_pkg, also used by the downstream command executor.
REQ-031 The inter-byte timer SHALL be one sub-module, byte_timeout_timer (inputs clear, enable; output expired).

Verification
REQ-032 Bytes 0x03, 0x12 with cmd_ready=1 -> cmd_valid one cycle after the second has_data, cmd_code=0x03, sensor_addr=0x12, one-cycle pulse.
REQ-033 Byte 0x09 -> frame_error pulse, state IDLE; then 0x01, 0x40 -> frame_error pulse, no cmd_valid.
REQ-034 Byte 0x02, then silence for TIMEOUT_CLOCKS (set to 16) -> frame_error pulse; then 0x05, 0x00 -> command 0x05/0x00.
REQ-035 Frame 0x04/0x1F with cmd_ready=0, extra byte 0x06 -> overrun pulse, command held at 0x04/0x1F; cmd_ready=1 -> accepted, cmd_valid low next cycle.
REQ-036 Reset pulse after byte 0x01 -> outputs zero; then 0x07, 0x0A -> command 0x07/0x0A.
REQ-037 Address byte arriving in the exact timeout cycle -> command issued, no frame_error.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared definitions for the command path: parser states, code limits and the
// command code map that the downstream executor decodes.
package cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ADDR = 2'd1,
        ST_HOLD      = 2'd2
    } parser_state_t;

    localparam logic [7:0] MAX_CODE_DEFAULT = 8'h07;
    localparam logic [7:0] MAX_ADDR_DEFAULT = 8'h1F;
    localparam int         ADDR_W           = 5;

    // Command codes understood by the executor.
    localparam logic [7:0] CMD_NOP        = 8'h00;
    localparam logic [7:0] CMD_READ       = 8'h01;
    localparam logic [7:0] CMD_WRITE      = 8'h02;
    localparam logic [7:0] CMD_RESET_SNS  = 8'h03;
    localparam logic [7:0] CMD_ENABLE     = 8'h04;
    localparam logic [7:0] CMD_DISABLE    = 8'h05;
    localparam logic [7:0] CMD_CALIBRATE  = 8'h06;
    localparam logic [7:0] CMD_SELF_TEST  = 8'h07;

endpackage

// File: rtl/byte_timeout_timer.sv
// Inter-byte timer: counts enabled clocks since the last clear and flags
// expiry once TIMEOUT_CLOCKS-1 counts have elapsed.
module byte_timeout_timer #(
    parameter int TIMEOUT_CLOCKS = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int             W    = (TIMEOUT_CLOCKS > 1) ? $clog2(TIMEOUT_CLOCKS) : 1;
    localparam logic [W-1:0]   LAST = W'(TIMEOUT_CLOCKS - 1);

    logic [W-1:0] r_count;

    // Clear has priority so the count restarts on the same edge the frame opens.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + W'(1);
        end
    end

    assign expired = (r_count == LAST);

endmodule

// File: rtl/cmd_frame_parser.sv
// Two-byte command frame parser (code byte, address byte) with inter-byte
// timeout, a held command output and registered error/overrun pulses.
module cmd_frame_parser
    import cmd_pkg::*;
#(
    parameter int         TIMEOUT_CLOCKS = 50000,
    parameter logic [7:0] MAX_CODE       = MAX_CODE_DEFAULT,
    parameter logic [7:0] MAX_ADDR       = MAX_ADDR_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        has_data,
    input  logic [7:0]  data_received,
    input  logic        cmd_ready,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic [4:0]  sensor_addr,
    output logic        frame_error,
    output logic        overrun,
    output logic [1:0]  o_dbg_state
);

    parser_state_t r_state;
    logic [7:0]    r_pend_code;
    logic          r_cmd_valid;
    logic [7:0]    r_cmd_code;
    logic [4:0]    r_sensor_addr;
    logic          r_frame_error;
    logic          r_overrun;

    parser_state_t w_state_nxt;
    logic [7:0]    w_pend_nxt;
    logic          w_valid_nxt;
    logic [7:0]    w_code_nxt;
    logic [4:0]    w_addr_nxt;
    logic          w_ferr_nxt;
    logic          w_ovr_nxt;
    logic          w_timer_clear;
    logic          w_timer_en;
    logic          w_expired;
    logic          w_code_ok;
    logic          w_addr_ok;

    assign w_code_ok = (data_received <= MAX_CODE);
    assign w_addr_ok = (data_received <= MAX_ADDR);

    byte_timeout_timer #(
        .TIMEOUT_CLOCKS(TIMEOUT_CLOCKS)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (w_timer_clear),
        .enable  (w_timer_en),
        .expired (w_expired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_pend_code   <= '0;
            r_cmd_valid   <= 1'b0;
            r_cmd_code    <= '0;
            r_sensor_addr <= '0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pend_code   <= w_pend_nxt;
            r_cmd_valid   <= w_valid_nxt;
            r_cmd_code    <= w_code_nxt;
            r_sensor_addr <= w_addr_nxt;
            r_frame_error <= w_ferr_nxt;
            r_overrun     <= w_ovr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pend_nxt    = r_pend_code;
        w_valid_nxt   = r_cmd_valid;
        w_code_nxt    = r_cmd_code;
        w_addr_nxt    = r_sensor_addr;
        w_ferr_nxt    = 1'b0;
        w_ovr_nxt     = 1'b0;
        w_timer_clear = 1'b0;
        w_timer_en    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_valid_nxt = 1'b0;
                if (has_data) begin
                    if (w_code_ok) begin
                        w_pend_nxt    = data_received;
                        w_timer_clear = 1'b1;
                        w_state_nxt   = ST_WAIT_ADDR;
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
                end
            end

            ST_WAIT_ADDR: begin
                w_timer_en = 1'b1;
                // A byte in the expiry cycle takes precedence over the timeout.
                if (has_data) begin
                    if (w_addr_ok) begin
                        w_code_nxt  = r_pend_code;
                        w_addr_nxt  = data_received[4:0];
                        w_valid_nxt = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_expired) begin
                    w_ferr_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_HOLD: begin
                if (cmd_ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                    // A byte arriving with the acceptance opens the next frame.
                    if (has_data) begin
                        if (w_code_ok) begin
                            w_pend_nxt    = data_received;
                            w_timer_clear = 1'b1;
                            w_state_nxt   = ST_WAIT_ADDR;
                        end else begin
                            w_ferr_nxt = 1'b1;
                        end
                    end
                end else if (has_data) begin
                    w_ovr_nxt = 1'b1;
                end
            end

            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign cmd_valid   = r_cmd_valid;
    assign cmd_code    = r_cmd_code;
    assign sensor_addr = r_sensor_addr;
    assign frame_error = r_frame_error;
    assign overrun     = r_overrun;
    assign o_dbg_state = r_state;

endmodule
